dtc_regfile: RTL and testbench

Parametrised DTC slow-control register file for the front-end card, successor to the fixed-size DTC command decoder. It decodes DTC read/write strobes into FEC configuration registers, double-buffers the APD bias DAC words so a new bias set is applied atomically on an update command, stretches reset commands to a programmable length, and flags illegal accesses. It sits between the DTC link receiver and the FEC power, temperature, readout and HV-DAC logic.

---
 rtl/dtc_pkg.sv | 32 +++
 rtl/dtc_hv_bank.sv | 53 +++++
 rtl/dtc_regfile.sv | 184 ++++++++++++++++++
 tb/tb_dtc_regfile.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dtc_pkg.sv
// Shared address map and helpers for the DTC slow-control register file.
package dtc_pkg;

  localparam logic [7:0] CMD_REG_EN        = 8'h01;
  localparam logic [7:0] CMD_STATUS        = 8'h02;
  localparam logic [7:0] CMD_MAP_ADDRESS   = 8'h03;
  localparam logic [7:0] CMD_THYST         = 8'h04;
  localparam logic [7:0] CMD_TOTI          = 8'h05;
  localparam logic [7:0] CMD_CHANNEL_MASK0 = 8'h06;
  localparam logic [7:0] CMD_CHANNEL_MASK1 = 8'h07;
  localparam logic [7:0] CMD_CHANNEL_MASK2 = 8'h08;
  localparam logic [7:0] CMD_CHANNEL_MASK3 = 8'h09;
  localparam logic [7:0] CMD_ALTRO_RESET   = 8'h19;
  localparam logic [7:0] CMD_FEE_RESET     = 8'h1A;
  localparam logic [7:0] CMD_HV_UPDATE     = 8'h1E;
  localparam logic [7:0] CMD_HV_PENDING    = 8'h1F;
  localparam logic [7:0] CMD_FIRMWARE      = 8'h20;
  localparam logic [7:0] CMD_ADC_DATA_BASE = 8'h50;
  localparam logic [7:0] CMD_HV_BASE       = 8'h60;
  localparam logic [7:0] CMD_SERIAL_NUMBER = 8'h80;

  localparam logic [31:0] ERR_READ_WORD = 32'hDEAD_BEEF;

  // True when addr falls in [base, base+span) and its offset is a populated channel.
  function automatic logic in_window(input logic [7:0] addr, input logic [7:0] base,
                                     input int unsigned span, input int unsigned n);
    logic [7:0] off;
    off = addr - base;
    return (addr >= base) && (32'(off) < span) && (32'(off) < n);
  endfunction

endpackage

// File: rtl/dtc_hv_bank.sv
// APD bias double buffer: shadow words collect writes, an update copies them
// all to the active bank in one cycle.
module dtc_hv_bank #(
  parameter int N_HV = 32,
  parameter int HV_W = 12
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_we,
  input  logic [4:0]                 i_wr_idx,
  input  logic [HV_W-1:0]            i_wr_data,
  input  logic                       i_update,
  input  logic [4:0]                 i_rd_idx,
  output logic [HV_W-1:0]            o_rd_data,
  output logic [N_HV-1:0][HV_W-1:0]  o_active,
  output logic                       o_pending
);

  logic [N_HV-1:0][HV_W-1:0] r_shadow;
  logic [N_HV-1:0][HV_W-1:0] r_active;
  logic                      r_pending;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shadow  <= '0;
      r_active  <= '0;
      r_pending <= 1'b0;
    end else begin
      if (i_update) begin
        r_active  <= r_shadow;
        r_pending <= 1'b0;
      end
      // A write in the update cycle misses this update and keeps pending set.
      if (i_we) begin
        for (int i = 0; i < N_HV; i++) begin
          if (i_wr_idx == 5'(i)) r_shadow[i] <= i_wr_data;
        end
        r_pending <= 1'b1;
      end
    end
  end

  always_comb begin
    o_rd_data = '0;
    for (int i = 0; i < N_HV; i++) begin
      if (i_rd_idx == 5'(i)) o_rd_data = r_shadow[i];
    end
  end

  assign o_active  = r_active;
  assign o_pending = r_pending;

endmodule

// File: rtl/dtc_regfile.sv
// DTC slow-control register file: decodes read/write strobes into FEC
// configuration, HV bias double buffer, stretched resets and access errors.
module dtc_regfile
  import dtc_pkg::*;
#(
  parameter int N_HV          = 32,
  parameter int N_ADC         = 15,
  parameter int HV_W          = 12,
  parameter int ADC_W         = 10,
  parameter int PWR_W         = 11,
  parameter int RST_PULSE_LEN = 4
) (
  input  logic                        dtc_clk,
  input  logic                        rst,
  input  logic [31:0]                 address,
  input  logic [31:0]                 write_data,
  input  logic                        write,
  input  logic                        read,
  output logic [31:0]                 read_data,
  output logic                        data_vld,
  output logic                        err,
  output logic [PWR_W-1:0]            reg_pwr_en,
  input  logic [15:0]                 status,
  output logic [7:0]                  thyst,
  output logic [7:0]                  toti,
  output logic [63:0]                 channel_mask,
  output logic                        altro_rst,
  output logic                        fee_rst,
  output logic                        hv_update,
  input  logic [15:0]                 firmware,
  input  logic [N_ADC-1:0][ADC_W-1:0] adc_data,
  output logic [N_HV-1:0][HV_W-1:0]   hv_dac_data
);

  localparam int CNT_W = $clog2(RST_PULSE_LEN + 1);

  logic [PWR_W-1:0]  r_pwr_en;
  logic [4:0]        r_map_addr;
  logic [7:0]        r_thyst;
  logic [7:0]        r_toti;
  logic [3:0][15:0]  r_mask;
  logic [31:0]       r_serial;
  logic              r_lock;
  logic [CNT_W-1:0]  r_altro_cnt;
  logic [CNT_W-1:0]  r_fee_cnt;
  logic [31:0]       r_read_data;
  logic              r_data_vld;
  logic              r_err;
  logic              r_hv_update;

  logic [7:0]        w_addr;
  logic              w_hi_ok;
  logic              w_adc_hit;
  logic              w_hv_hit;
  logic              w_rd_ok;
  logic              w_wr_ok;
  logic [31:0]       w_rd_word;
  logic              w_wr_go;
  logic              w_hv_we;
  logic              w_hv_upd;
  logic [HV_W-1:0]   w_shadow_rd;
  logic              w_pending;

  assign w_addr    = address[7:0];
  assign w_hi_ok   = (address[31:8] == 24'd0);
  assign w_adc_hit = in_window(w_addr, CMD_ADC_DATA_BASE, 16, N_ADC);
  assign w_hv_hit  = in_window(w_addr, CMD_HV_BASE, 32, N_HV);

  always_comb begin
    w_rd_word = '0;
    w_rd_ok   = 1'b0;
    w_wr_ok   = 1'b0;
    case (w_addr)
      CMD_REG_EN:        begin w_rd_word = 32'(r_pwr_en);   w_rd_ok = 1'b1; w_wr_ok = 1'b1; end
      CMD_STATUS:        begin w_rd_word = 32'(status);     w_rd_ok = 1'b1; end
      CMD_MAP_ADDRESS:   begin w_rd_word = 32'(r_map_addr); w_rd_ok = 1'b1; w_wr_ok = 1'b1; end
      CMD_THYST:         begin w_rd_word = 32'(r_thyst);    w_rd_ok = 1'b1; w_wr_ok = 1'b1; end
      CMD_TOTI:          begin w_rd_word = 32'(r_toti);     w_rd_ok = 1'b1; w_wr_ok = 1'b1; end
      CMD_CHANNEL_MASK0: begin w_rd_word = 32'(r_mask[0]);  w_rd_ok = 1'b1; w_wr_ok = 1'b1; end
      CMD_CHANNEL_MASK1: begin w_rd_word = 32'(r_mask[1]);  w_rd_ok = 1'b1; w_wr_ok = 1'b1; end
      CMD_CHANNEL_MASK2: begin w_rd_word = 32'(r_mask[2]);  w_rd_ok = 1'b1; w_wr_ok = 1'b1; end
      CMD_CHANNEL_MASK3: begin w_rd_word = 32'(r_mask[3]);  w_rd_ok = 1'b1; w_wr_ok = 1'b1; end
      CMD_ALTRO_RESET,
      CMD_FEE_RESET,
      CMD_HV_UPDATE:     w_wr_ok = 1'b1;
      CMD_HV_PENDING:    begin w_rd_word = 32'(w_pending);  w_rd_ok = 1'b1; end
      CMD_FIRMWARE:      begin w_rd_word = 32'(firmware);   w_rd_ok = 1'b1; end
      CMD_SERIAL_NUMBER: begin w_rd_word = r_serial;        w_rd_ok = 1'b1; w_wr_ok = !r_lock; end
      default: begin
        if (w_adc_hit) begin
          w_rd_ok = 1'b1;
          for (int i = 0; i < N_ADC; i++) begin
            if (w_addr[3:0] == 4'(i)) w_rd_word = 32'(adc_data[i]);
          end
        end else if (w_hv_hit) begin
          w_rd_word = 32'(w_shadow_rd);
          w_rd_ok   = 1'b1;
          w_wr_ok   = 1'b1;
        end
      end
    endcase
    if (!w_hi_ok) begin
      w_rd_ok = 1'b0;
      w_wr_ok = 1'b0;
    end
  end

  assign w_wr_go  = write && w_wr_ok;
  assign w_hv_we  = w_wr_go && w_hv_hit;
  assign w_hv_upd = w_wr_go && (w_addr == CMD_HV_UPDATE);

  dtc_hv_bank #(
    .N_HV (N_HV),
    .HV_W (HV_W)
  ) u_hv_bank (
    .i_clk     (dtc_clk),
    .i_rst     (rst),
    .i_we      (w_hv_we),
    .i_wr_idx  (w_addr[4:0]),
    .i_wr_data (write_data[HV_W-1:0]),
    .i_update  (w_hv_upd),
    .i_rd_idx  (w_addr[4:0]),
    .o_rd_data (w_shadow_rd),
    .o_active  (hv_dac_data),
    .o_pending (w_pending)
  );

  always_ff @(posedge dtc_clk) begin
    if (rst) begin
      r_pwr_en    <= '0;
      r_map_addr  <= '0;
      r_thyst     <= '0;
      r_toti      <= '0;
      r_mask      <= '0;
      r_serial    <= '0;
      r_lock      <= 1'b0;
      r_altro_cnt <= '0;
      r_fee_cnt   <= '0;
      r_read_data <= '0;
      r_data_vld  <= 1'b0;
      r_err       <= 1'b0;
      r_hv_update <= 1'b0;
    end else begin
      r_data_vld  <= read;
      r_err       <= (read && !w_rd_ok) || (write && !w_wr_ok);
      r_hv_update <= w_hv_upd;
      if (r_altro_cnt != '0) r_altro_cnt <= r_altro_cnt - CNT_W'(1);
      if (r_fee_cnt != '0)   r_fee_cnt   <= r_fee_cnt - CNT_W'(1);
      // Read data comes from pre-write state, so a same-cycle write is not seen.
      if (read) r_read_data <= w_rd_ok ? w_rd_word : ERR_READ_WORD;
      if (w_wr_go) begin
        case (w_addr)
          CMD_REG_EN:        r_pwr_en    <= write_data[PWR_W-1:0];
          CMD_MAP_ADDRESS:   r_map_addr  <= write_data[4:0];
          CMD_THYST:         r_thyst     <= write_data[7:0];
          CMD_TOTI:          r_toti      <= write_data[7:0];
          CMD_CHANNEL_MASK0: r_mask[0]   <= write_data[15:0];
          CMD_CHANNEL_MASK1: r_mask[1]   <= write_data[15:0];
          CMD_CHANNEL_MASK2: r_mask[2]   <= write_data[15:0];
          CMD_CHANNEL_MASK3: r_mask[3]   <= write_data[15:0];
          CMD_ALTRO_RESET:   r_altro_cnt <= CNT_W'(RST_PULSE_LEN);
          CMD_FEE_RESET:     r_fee_cnt   <= CNT_W'(RST_PULSE_LEN);
          CMD_SERIAL_NUMBER: begin
            r_serial <= write_data;
            r_lock   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign read_data    = r_read_data;
  assign data_vld     = r_data_vld;
  assign err          = r_err;
  assign reg_pwr_en   = r_pwr_en;
  assign thyst        = r_thyst;
  assign toti         = r_toti;
  assign channel_mask = r_mask;
  assign altro_rst    = (r_altro_cnt != '0);
  assign fee_rst      = (r_fee_cnt != '0);
  assign hv_update    = r_hv_update;

endmodule

// File: tb/tb_dtc_regfile.sv
// Self-checking bench for dtc_regfile: vector table plus hand-written
// sequences, with a scoreboard queue for per-cycle read/err expectations.
module tb_dtc_regfile;

  localparam int N_HV = 8, N_ADC = 15, HV_W = 12, ADC_W = 10, PWR_W = 11, RST_PULSE_LEN = 4;

  logic                        dtc_clk = 1'b0;
  logic                        rst = 1'b1;
  logic [31:0]                 address = '0;
  logic [31:0]                 write_data = '0;
  logic                        write = 1'b0;
  logic                        read = 1'b0;
  logic [31:0]                 read_data;
  logic                        data_vld;
  logic                        err;
  logic [PWR_W-1:0]            reg_pwr_en;
  logic [15:0]                 status = 16'hC3A5;
  logic [7:0]                  thyst;
  logic [7:0]                  toti;
  logic [63:0]                 channel_mask;
  logic                        altro_rst;
  logic                        fee_rst;
  logic                        hv_update;
  logic [15:0]                 firmware = 16'h0102;
  logic [N_ADC-1:0][ADC_W-1:0] adc_data;
  logic [N_HV-1:0][HV_W-1:0]   hv_dac_data;

  dtc_regfile #(
    .N_HV(N_HV), .N_ADC(N_ADC), .HV_W(HV_W), .ADC_W(ADC_W),
    .PWR_W(PWR_W), .RST_PULSE_LEN(RST_PULSE_LEN)
  ) dut (
    .dtc_clk(dtc_clk), .rst(rst), .address(address), .write_data(write_data),
    .write(write), .read(read), .read_data(read_data), .data_vld(data_vld),
    .err(err), .reg_pwr_en(reg_pwr_en), .status(status), .thyst(thyst),
    .toti(toti), .channel_mask(channel_mask), .altro_rst(altro_rst),
    .fee_rst(fee_rst), .hv_update(hv_update), .firmware(firmware),
    .adc_data(adc_data), .hv_dac_data(hv_dac_data)
  );

  always #5 dtc_clk = ~dtc_clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        vld;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic        vld;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   altro_hi = 0, altro_rise = 0, fee_hi = 0, fee_rise = 0;
  logic altro_prev = 1'b0, fee_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t v(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] wd, input logic ev, input logic [31:0] ed,
                             input logic ee);
    vec_t t;
    t.rd = rd; t.wr = wr; t.addr = a; t.wdata = wd; t.vld = ev; t.rdata = ed; t.err = ee;
    return t;
  endfunction

  task automatic drive(input logic r, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic ev, input logic [31:0] ed,
                       input logic ee);
    exp_t e;
    @(negedge dtc_clk);
    rst = r; read = rd; write = wr; address = a; write_data = wd;
    e.addr = a; e.vld = ev; e.data = ed; e.err = ee;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic after_edge();
    @(posedge dtc_clk);
    #2;
  endtask

  // Monitor: one expectation per driven cycle, compared just after the edge.
  always @(posedge dtc_clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk($sformatf("data_vld@%h", e.addr), 32'(data_vld), 32'(e.vld));
      chk($sformatf("err@%h", e.addr), 32'(err), 32'(e.err));
      if (e.vld) chk($sformatf("read_data@%h", e.addr), read_data, e.data);
    end
    if (altro_rst) altro_hi++;
    if (altro_rst && !altro_prev) altro_rise++;
    altro_prev = altro_rst;
    if (fee_rst) fee_hi++;
    if (fee_rst && !fee_prev) fee_rise++;
    fee_prev = fee_rst;
  end

  initial begin
    for (int i = 0; i < N_ADC; i++) adc_data[i] = ADC_W'(i * 37 + 5);

    tbl.push_back(v(1, 0, 32'h01, 0, 1, 32'h0, 0));
    tbl.push_back(v(1, 0, 32'h09, 0, 1, 32'h0, 0));
    tbl.push_back(v(1, 0, 32'h60, 0, 1, 32'h0, 0));
    tbl.push_back(v(1, 0, 32'h1F, 0, 1, 32'h0, 0));
    tbl.push_back(v(0, 1, 32'h01, 32'hFFFF_FFFF, 0, 0, 0));
    tbl.push_back(v(1, 0, 32'h01, 0, 1, 32'h0000_07FF, 0));
    tbl.push_back(v(0, 1, 32'h06, 32'h1234_ABCD, 0, 0, 0));
    tbl.push_back(v(0, 1, 32'h09, 32'h0000_5A5A, 0, 0, 0));
    tbl.push_back(v(1, 0, 32'h06, 0, 1, 32'h0000_ABCD, 0));
    tbl.push_back(v(1, 0, 32'h09, 0, 1, 32'h0000_5A5A, 0));
    tbl.push_back(v(0, 1, 32'h03, 32'h0000_00FF, 0, 0, 0));
    tbl.push_back(v(1, 0, 32'h03, 0, 1, 32'h0000_001F, 0));
    tbl.push_back(v(1, 0, 32'h02, 0, 1, 32'h0000_C3A5, 0));
    tbl.push_back(v(1, 0, 32'h20, 0, 1, 32'h0000_0102, 0));
    tbl.push_back(v(1, 0, 32'h50, 0, 1, 32'd5, 0));
    tbl.push_back(v(1, 0, 32'h5E, 0, 1, 32'd523, 0));
    tbl.push_back(v(1, 0, 32'h5F, 0, 1, 32'hDEAD_BEEF, 1));
    tbl.push_back(v(0, 1, 32'h02, 32'h1, 0, 0, 1));
    tbl.push_back(v(1, 0, 32'h19, 0, 1, 32'hDEAD_BEEF, 1));
    tbl.push_back(v(1, 0, 32'h1A, 0, 1, 32'hDEAD_BEEF, 1));
    tbl.push_back(v(1, 0, 32'h1E, 0, 1, 32'hDEAD_BEEF, 1));
    tbl.push_back(v(1, 0, 32'h4F, 0, 1, 32'hDEAD_BEEF, 1));
    tbl.push_back(v(1, 0, 32'h68, 0, 1, 32'hDEAD_BEEF, 1));
    tbl.push_back(v(1, 0, 32'h0A, 0, 1, 32'hDEAD_BEEF, 1));
    tbl.push_back(v(1, 0, 32'h100, 0, 1, 32'hDEAD_BEEF, 1));
    tbl.push_back(v(0, 1, 32'h104, 32'h7, 0, 0, 1));
    tbl.push_back(v(0, 1, 32'h50, 32'h7, 0, 0, 1));
    tbl.push_back(v(0, 1, 32'h1F, 32'h7, 0, 0, 1));
    tbl.push_back(v(0, 1, 32'h04, 32'h0000_0022, 0, 0, 0));
    tbl.push_back(v(0, 1, 32'h05, 32'h0000_017E, 0, 0, 0));

    // Reset
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    after_edge();
    chk("rst read_data", read_data, 32'h0);
    chk("rst reg_pwr_en", 32'(reg_pwr_en), 32'h0);
    chk("rst hv_dac_data3", 32'(hv_dac_data[3]), 32'h0);
    chk("rst resets", {29'd0, hv_update, altro_rst, fee_rst}, 32'h0);

    // Table vectors
    foreach (tbl[i]) drive(1'b0, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata,
                           tbl[i].vld, tbl[i].rdata, tbl[i].err);
    after_edge();
    chk("reg_pwr_en", 32'(reg_pwr_en), 32'h0000_07FF);
    chk("mask_lo", channel_mask[31:0], 32'h0000_ABCD);
    chk("mask_hi", channel_mask[63:32], 32'h5A5A_0000);
    chk("thyst", 32'(thyst), 32'h22);
    chk("toti", 32'(toti), 32'h7E);

    // HV double buffer
    drive(0, 0, 1, 32'h63, 32'h0000_0ABC, 0, 0, 0);
    drive(0, 1, 0, 32'h63, 0, 1, 32'h0000_0ABC, 0);
    after_edge();
    chk("hv3 before update", 32'(hv_dac_data[3]), 32'h0);
    drive(0, 1, 0, 32'h1F, 0, 1, 32'h1, 0);
    drive(0, 0, 1, 32'h1E, 0, 0, 0, 0);
    after_edge();
    chk("hv_update pulse", 32'(hv_update), 32'h1);
    chk("hv3 after update", 32'(hv_dac_data[3]), 32'h0000_0ABC);
    chk("hv2 after update", 32'(hv_dac_data[2]), 32'h0);
    drive(0, 1, 0, 32'h1F, 0, 1, 32'h0, 0);
    after_edge();
    chk("hv_update end", 32'(hv_update), 32'h0);

    // ALTRO reset with rewrite two cycles later, then a plain FEE reset
    altro_hi = 0; altro_rise = 0; fee_hi = 0; fee_rise = 0;
    drive(0, 0, 1, 32'h19, 0, 0, 0, 0);
    idle(1);
    drive(0, 0, 1, 32'h19, 0, 0, 0, 0);
    idle(10);
    drive(0, 0, 1, 32'h1A, 0, 0, 0, 0);
    idle(8);
    after_edge();
    chk("altro_rst cycles", 32'(altro_hi), 32'd6);
    chk("altro_rst rises", 32'(altro_rise), 32'd1);
    chk("fee_rst cycles", 32'(fee_hi), 32'd4);

    // Serial number write-once
    drive(0, 0, 1, 32'h80, 32'h0000_1234, 0, 0, 0);
    drive(0, 0, 1, 32'h80, 32'h0000_5678, 0, 0, 1);
    drive(0, 1, 0, 32'h80, 0, 1, 32'h0000_1234, 0);

    // Simultaneous read and write of THYST
    drive(0, 1, 1, 32'h04, 32'h55, 1, 32'h22, 0);
    after_edge();
    chk("thyst after rw", 32'(thyst), 32'h55);
    drive(0, 1, 0, 32'h04, 0, 1, 32'h55, 0);

    // Reset mid-pulse, and reset together with a FEE reset write
    drive(0, 0, 1, 32'h19, 0, 0, 0, 0);
    after_edge();
    chk("altro before rst", 32'(altro_rst), 32'h1);
    fee_rise = 0;
    drive(1, 0, 1, 32'h1A, 0, 0, 0, 0);
    after_edge();
    chk("altro after rst", 32'(altro_rst), 32'h0);
    chk("fee after rst", 32'(fee_rst), 32'h0);
    chk("thyst after rst", 32'(thyst), 32'h0);
    idle(3);
    after_edge();
    chk("fee never rose", 32'(fee_rise), 32'd0);
    drive(0, 0, 1, 32'h80, 32'h0000_9999, 0, 0, 0);
    drive(0, 1, 0, 32'h80, 0, 1, 32'h0000_9999, 0);
    drive(0, 1, 0, 32'h63, 0, 1, 32'h0, 0);
    idle(2);
    after_edge();
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
